// File: rtl/axis_pkt_framer.sv
// C2H packetiser: records tagged with a running sequence number are collected in a ring of
// buffers and each closed buffer is streamed out as one tlast-terminated AXIS burst.
module axis_pkt_framer #(
    parameter int DATA_WIDTH      = 16000,
    parameter int AXIS_DATA_WIDTH = 512,
    parameter int NUM_BUFS        = 2,
    parameter int PKTS_PER_BUF    = 8,
    parameter int SEQ_WIDTH       = 8,
    parameter int FLUSH_TIMEOUT   = 1024
) (
    input  logic                              m_axis_c2h_aclk,
    input  logic                              m_axis_c2h_aresetn,
    input  logic [DATA_WIDTH-1:0]             data,
    input  logic                              data_valid,
    output logic                              data_next,
    input  logic                              flush_req,
    output logic [AXIS_DATA_WIDTH-1:0]        m_axis_c2h_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0]      m_axis_c2h_tkeep,
    output logic                              m_axis_c2h_tlast,
    output logic                              m_axis_c2h_tvalid,
    input  logic                              m_axis_c2h_tready,
    output logic [$clog2(NUM_BUFS+1)-1:0]     bufs_closed,
    output logic [3:0]                        sstate
);
    localparam int REC_W      = DATA_WIDTH + SEQ_WIDTH;
    localparam int BEATS      = (REC_W + AXIS_DATA_WIDTH - 1) / AXIS_DATA_WIDTH;
    localparam int SR_W       = BEATS * AXIS_DATA_WIDTH;
    localparam int KB         = AXIS_DATA_WIDTH / 8;
    localparam int LAST_BYTES = (REC_W - (BEATS - 1) * AXIS_DATA_WIDTH + 7) / 8;
    localparam int PTR_W      = $clog2(NUM_BUFS);
    localparam int CNT_W      = $clog2(PKTS_PER_BUF + 1);
    localparam int SLOT_W     = (PKTS_PER_BUF > 1) ? $clog2(PKTS_PER_BUF) : 1;
    localparam int BC_W       = $clog2(NUM_BUFS + 1);
    localparam int BEAT_W     = $clog2(BEATS + 1);
    localparam int IDLE_W     = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
    localparam logic [KB-1:0] KEEP_LAST = {KB{1'b1}} >> (KB - LAST_BYTES);

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_LOAD = 4'b0010,
        S_SEND = 4'b0100,
        S_DONE = 4'b1000
    } state_t;

    logic [DATA_WIDTH-1:0] buf_mem [NUM_BUFS][PKTS_PER_BUF];
    logic [CNT_W-1:0]      fill [NUM_BUFS];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      wr_cnt, wr_cnt_inc, rd_cnt;
    logic [IDLE_W-1:0]     idle_cnt;
    logic                  accept, close, done;
    state_t                state;
    logic [SEQ_WIDTH-1:0]  seq;
    logic [SR_W-1:0]       sr, rec_w, pres_src;
    logic [BEAT_W-1:0]     beats_out, pres_bn;
    logic                  rec_end, do_pres, pres_tail, pres_last;

    assign data_next  = (bufs_closed != BC_W'(NUM_BUFS));
    assign accept     = data_valid && data_next;
    assign wr_cnt_inc = wr_cnt + CNT_W'(accept);
    assign close      = (accept && wr_cnt_inc == CNT_W'(PKTS_PER_BUF))
                     || (flush_req && wr_cnt != '0)
                     || (FLUSH_TIMEOUT != 0 && !accept && wr_cnt != '0
                         && idle_cnt == IDLE_W'(FLUSH_TIMEOUT - 1));
    assign done       = (state == S_DONE);
    assign sstate     = state;

    always_ff @(posedge m_axis_c2h_aclk) begin
        if (accept)
            buf_mem[wr_ptr][wr_cnt[SLOT_W-1:0]] <= data;
    end

    always_ff @(posedge m_axis_c2h_aclk) begin
        if (!m_axis_c2h_aresetn) begin
            wr_ptr   <= '0;
            wr_cnt   <= '0;
            idle_cnt <= '0;
            for (int i = 0; i < NUM_BUFS; i++) fill[i] <= '0;
        end else begin
            if (close) begin
                fill[wr_ptr] <= wr_cnt_inc;
                wr_ptr       <= wr_ptr + PTR_W'(1);
                wr_cnt       <= '0;
            end else begin
                wr_cnt <= wr_cnt_inc;
            end
            if (accept || close || wr_cnt == '0) idle_cnt <= '0;
            else                                 idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    always_ff @(posedge m_axis_c2h_aclk) begin
        if (!m_axis_c2h_aresetn)  bufs_closed <= '0;
        else if (close && !done)  bufs_closed <= bufs_closed + BC_W'(1);
        else if (!close && done)  bufs_closed <= bufs_closed - BC_W'(1);
    end

    // Record image for the slot under the read cursor, tagged with the current seq.
    assign rec_w = SR_W'({buf_mem[rd_ptr][rd_cnt[SLOT_W-1:0]], seq});

    // The first record of a burst is presented from SEND; later records go straight
    // from LOAD so the gap between records is a single cycle.
    always_comb begin
        rec_end   = m_axis_c2h_tvalid && m_axis_c2h_tready && beats_out == BEAT_W'(BEATS);
        do_pres   = (state == S_LOAD && rd_cnt != '0)
                 || (state == S_SEND && !rec_end && (!m_axis_c2h_tvalid || m_axis_c2h_tready));
        pres_src  = (state == S_LOAD) ? rec_w : sr;
        pres_bn   = (state == S_LOAD) ? '0 : beats_out;
        pres_tail = (state == S_LOAD) ? (rd_cnt + CNT_W'(1) == fill[rd_ptr])
                                      : (rd_cnt == fill[rd_ptr]);
        pres_last = (pres_bn == BEAT_W'(BEATS - 1)) && pres_tail;
    end

    always_ff @(posedge m_axis_c2h_aclk) begin
        if (!m_axis_c2h_aresetn) begin
            state             <= S_IDLE;
            rd_ptr            <= '0;
            rd_cnt            <= '0;
            seq               <= '0;
            sr                <= '0;
            beats_out         <= '0;
            m_axis_c2h_tdata  <= '0;
            m_axis_c2h_tkeep  <= '0;
            m_axis_c2h_tlast  <= 1'b0;
            m_axis_c2h_tvalid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bufs_closed != '0) state <= S_LOAD;
                S_LOAD: begin
                    seq    <= seq + SEQ_WIDTH'(1);
                    rd_cnt <= rd_cnt + CNT_W'(1);
                    state  <= S_SEND;
                    if (rd_cnt == '0) begin
                        sr        <= rec_w;
                        beats_out <= '0;
                    end
                end
                S_SEND: if (rec_end) begin
                    m_axis_c2h_tvalid <= 1'b0;
                    m_axis_c2h_tlast  <= 1'b0;
                    m_axis_c2h_tkeep  <= '0;
                    state             <= (rd_cnt == fill[rd_ptr]) ? S_DONE : S_LOAD;
                end
                S_DONE: begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                    rd_cnt <= '0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            if (do_pres) begin
                m_axis_c2h_tvalid <= 1'b1;
                m_axis_c2h_tdata  <= pres_src[AXIS_DATA_WIDTH-1:0];
                m_axis_c2h_tlast  <= pres_last;
                m_axis_c2h_tkeep  <= pres_last ? KEEP_LAST : '1;
                sr                <= pres_src >> AXIS_DATA_WIDTH;
                beats_out         <= pres_bn + BEAT_W'(1);
            end
        end
    end
endmodule
